// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard unit.
// Imported by the interface, the top and any pipeline stage that builds bubbles.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 3;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic       valid;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
  } id_ex_ctrl_t;

  // Control word the ID/EX register loads when a bubble is requested.
  localparam id_ex_ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Decode/ID-EX side bundle seen by the hazard unit.
// master = pipeline side, slave = hazard unit.
interface hazard_detection_unit_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 16
);

  logic [REG_ADDR_W-1:0] i_rs_id;
  logic [REG_ADDR_W-1:0] i_rt_id;
  logic                  i_rs_used_id;
  logic                  i_rt_used_id;
  logic                  i_valid_id;
  logic [REG_ADDR_W-1:0] i_rd_idex;
  logic                  i_mem_read_idex;
  logic                  i_wb_idex;
  logic                  i_valid_idex;
  logic                  i_flush;

  logic                  o_stall_pc;
  logic                  o_stall_ifid;
  logic                  o_bubble_idex;
  logic                  o_freeze;
  logic                  o_busy;
  logic [CNT_W-1:0]      o_stall_cycles;

  modport master (
    output i_rs_id, i_rt_id,
    output i_rs_used_id, i_rt_used_id,
    output i_valid_id, i_rd_idex,
    output i_mem_read_idex, i_wb_idex,
    output i_valid_idex, i_flush,
    input  o_stall_pc, o_stall_ifid,
    input  o_bubble_idex, o_freeze,
    input  o_busy, o_stall_cycles
  );

  modport slave (
    input  i_rs_id, i_rt_id,
    input  i_rs_used_id, i_rt_used_id,
    input  i_valid_id, i_rd_idex,
    input  i_mem_read_idex, i_wb_idex,
    input  i_valid_idex, i_flush,
    output o_stall_pc, o_stall_ifid,
    output o_bubble_idex, o_freeze,
    output o_busy, o_stall_cycles
  );

endinterface

// File: rtl/hazard_detection_unit_mem_wait_counter.sv
// Loadable down-counter timing a multi-cycle data-memory read.
// done flags the last frozen cycle (count == 1).
module mem_wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use stall and multi-cycle load freeze for the decode stage.
// Define HAZARD_PERF_EN to build the saturating stall-cycle counter.
module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MEM_LAT    = 2,
  parameter int CNT_W      = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  hazard_detection_unit_if.slave hz
);

  localparam int CW = $clog2(MEM_LAT + 1);

  hz_state_t state;
  hz_state_t state_nxt;

  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic rs_hit;
  logic rt_hit;
  logic lu;
  logic frz;
  logic stall;
  logic bubble;
  logic cnt_load;
  logic cnt_done;

  assign rs = hz.i_rs_id;
  assign rt = hz.i_rt_id;
  assign rd = hz.i_rd_idex;

  assign rs_hit = hz.i_rs_used_id & (rs == rd);
  assign rt_hit = hz.i_rt_used_id & (rt == rd);

  assign lu = hz.i_valid_id
            & hz.i_valid_idex
            & hz.i_mem_read_idex
            & hz.i_wb_idex
            & (rs_hit | rt_hit);

  assign frz = (state == MEM_WAIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The load leaves ID/EX for MEM on the edge that leaves IDLE.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    unique case (state)
      IDLE: begin
        if (hz.i_valid_idex && hz.i_mem_read_idex &&
            MEM_LAT > 1) begin
          state_nxt = MEM_WAIT;
          cnt_load  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (cnt_done) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  mem_wait_counter #(
    .W (CW)
  ) u_wait (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (cnt_load),
    .load_val (CW'(MEM_LAT - 1)),
    .done     (cnt_done)
  );

  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    unique case (1'b1)
      frz: begin
        stall = 1'b1;
      end
      !frz && hz.i_flush: begin
        stall = 1'b0;
      end
      !frz && !hz.i_flush && lu: begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  assign hz.o_stall_pc    = i_rst_n & stall;
  assign hz.o_stall_ifid  = i_rst_n & stall;
  assign hz.o_bubble_idex = i_rst_n & bubble;
  assign hz.o_freeze      = i_rst_n & frz;
  assign hz.o_busy        = i_rst_n & frz;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign hz.o_stall_cycles = stall_cnt;
`else
  assign hz.o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: three latencies (1, 3, 4) share one stimulus
// stream; vectors, corner sequences and random traffic vs a cycle model.
module tb_hazard_detection_unit;

  localparam int AW   = 3;
  localparam int CW   = 4;
  localparam int NDUT = 3;
  localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic rsu;
    logic rtu;
    logic vid;
    logic mr;
    logic wb;
    logic vx;
    logic fl;
  } stim_t;

  typedef struct packed {
    stim_t s;
    logic  st;
  } vec_t;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b0;
  stim_t cur   = '0;

  always #5 clk = ~clk;

  logic          o_pc   [NDUT];
  logic          o_ifid [NDUT];
  logic          o_bub  [NDUT];
  logic          o_frz  [NDUT];
  logic          o_busy [NDUT];
  logic [CW-1:0] o_cnt  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    hazard_detection_unit_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus ();

    hazard_detection_unit #(
      .REG_ADDR_W (AW),
      .MEM_LAT    ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
      .CNT_W      (CW)
    ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .hz      (bus)
    );

    assign bus.i_rs_id         = cur.rs;
    assign bus.i_rt_id         = cur.rt;
    assign bus.i_rs_used_id    = cur.rsu;
    assign bus.i_rt_used_id    = cur.rtu;
    assign bus.i_valid_id      = cur.vid;
    assign bus.i_rd_idex       = cur.rd;
    assign bus.i_mem_read_idex = cur.mr;
    assign bus.i_wb_idex       = cur.wb;
    assign bus.i_valid_idex    = cur.vx;
    assign bus.i_flush         = cur.fl;

    assign o_pc[g]   = bus.o_stall_pc;
    assign o_ifid[g] = bus.o_stall_ifid;
    assign o_bub[g]  = bus.o_bubble_idex;
    assign o_frz[g]  = bus.o_freeze;
    assign o_busy[g] = bus.o_busy;
    assign o_cnt[g]  = bus.o_stall_cycles;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int rem  [NDUT];
  int pcnt [NDUT];

  function automatic int lat(int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
  endfunction

  function automatic stim_t mk(int rs, int rt, bit rsu, bit rtu, bit vid,
                               int rd, bit mr, bit wb, bit vx, bit fl);
    stim_t s;
    s.rs  = AW'(rs);
    s.rt  = AW'(rt);
    s.rd  = AW'(rd);
    s.rsu = rsu;
    s.rtu = rtu;
    s.vid = vid;
    s.mr  = mr;
    s.wb  = wb;
    s.vx  = vx;
    s.fl  = fl;
    return s;
  endfunction

  function automatic bit lu_of(stim_t s);
    return s.vid && s.vx && s.mr && s.wb &&
           ((s.rsu && s.rs == s.rd) || (s.rtu && s.rt == s.rd));
  endfunction

  function automatic bit exp_stall(int g);
    bit f;
    f = (rem[g] > 0);
    return f || (!cur.fl && lu_of(cur));
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int g = 0; g < NDUT; g++) begin
      rem[g]  = 0;
      pcnt[g] = 0;
    end
  endtask

  task automatic check_model();
    for (int g = 0; g < NDUT; g++) begin
      bit f;
      bit st;
      bit bb;
      string p;
      p  = $sformatf("lat%0d", lat(g));
      f  = rst_n && (rem[g] > 0);
      st = rst_n && exp_stall(g);
      bb = rst_n && !f && !cur.fl && lu_of(cur);
      chk({p, ".stall_pc"},   o_pc[g],   st);
      chk({p, ".stall_ifid"}, o_ifid[g], st);
      chk({p, ".bubble"},     o_bub[g],  bb);
      chk({p, ".freeze"},     o_frz[g],  f);
      chk({p, ".busy"},       o_busy[g], f);
      chk({p, ".stall_cyc"},  o_cnt[g],  PERF ? pcnt[g] : 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    if (!rst_n) begin
      reset_model();
    end else begin
      for (int g = 0; g < NDUT; g++) begin
        if (exp_stall(g) && pcnt[g] < CMAX) pcnt[g]++;
        if (rem[g] > 0) rem[g]--;
        else if (cur.vx && cur.mr && lat(g) > 1) rem[g] = lat(g) - 1;
      end
    end
    #1;
  endtask

  task automatic idle(int n);
    cur = '0;
    repeat (n) tick();
  endtask

  vec_t  tbl [11];
  stim_t lu_s;
  stim_t ld_s;

  initial begin
    reset_model();
    lu_s = mk(3, 0, 1, 0, 1, 3, 1, 1, 1, 0);
    ld_s = mk(1, 2, 1, 1, 1, 5, 1, 1, 1, 0);

    tbl[0]  = '{mk(3, 0, 1, 0, 1, 3, 1, 1, 1, 0), 1'b1};
    tbl[1]  = '{mk(3, 3, 0, 0, 1, 3, 1, 1, 1, 0), 1'b0};
    tbl[2]  = '{mk(3, 0, 1, 0, 1, 3, 1, 0, 1, 0), 1'b0};
    tbl[3]  = '{mk(0, 5, 0, 1, 1, 5, 1, 1, 1, 0), 1'b1};
    tbl[4]  = '{mk(3, 0, 1, 0, 1, 3, 1, 1, 1, 1), 1'b0};
    tbl[5]  = '{mk(3, 0, 1, 0, 0, 3, 1, 1, 1, 0), 1'b0};
    tbl[6]  = '{mk(3, 0, 1, 0, 1, 3, 1, 1, 0, 0), 1'b0};
    tbl[7]  = '{mk(3, 0, 1, 0, 1, 3, 0, 1, 1, 0), 1'b0};
    tbl[8]  = '{mk(0, 0, 1, 1, 1, 0, 1, 1, 1, 0), 1'b1};
    tbl[9]  = '{mk(2, 4, 1, 1, 1, 6, 1, 1, 1, 0), 1'b0};
    tbl[10] = '{mk(7, 7, 1, 0, 1, 7, 1, 1, 1, 0), 1'b1};

    // Reset with a load-use pattern present: everything must stay low.
    cur = lu_s;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("rst.stall_pc%0d", g), o_pc[g], 0);
      chk($sformatf("rst.bubble%0d", g), o_bub[g], 0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < 11; i++) begin
      cur = tbl[i].s;
      #1;
      chk($sformatf("vec%0d.stall", i), o_pc[0], tbl[i].st);
      chk($sformatf("vec%0d.bubble", i), o_bub[0], tbl[i].st);
      tick();
    end
    idle(5);

    // Load-use, single-cycle memory: one stall then the bubble clears it.
    cur = lu_s;
    #1;
    chk("lu.stall_pc", o_pc[0], 1);
    chk("lu.stall_ifid", o_ifid[0], 1);
    chk("lu.bubble", o_bub[0], 1);
    tick();
    cur = lu_s;
    cur.vx = 1'b0;
    #1;
    chk("lu.next_stall", o_pc[0], 0);
    chk("lu.next_bubble", o_bub[0], 0);
    tick();
    idle(5);

    // Load entering MEM: freeze MEM_LAT-1 cycles.
    cur = ld_s;
    #1;
    chk("ld.pre_freeze3", o_frz[1], 0);
    tick();
    cur = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("frz3.k%0d", k), o_frz[1], k < 2);
      chk($sformatf("busy3.k%0d", k), o_busy[1], k < 2);
      chk($sformatf("bub3.k%0d", k), o_bub[1], 0);
      chk($sformatf("frz4.k%0d", k), o_frz[2], k < 3);
      tick();
    end
    idle(5);

    // Flush during MEM_WAIT, second load waiting behind the first.
    cur = ld_s;
    tick();
    cur = lu_s;
    cur.fl = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("fl.frz3.k%0d", k), o_frz[1], k != 2);
      chk($sformatf("fl.frz4.k%0d", k), o_frz[2], k != 3);
      chk($sformatf("fl.pc3.k%0d", k), o_pc[1], k != 2);
      tick();
    end
    idle(6);

    // Asynchronous reset in the middle of a MEM_LAT=4 freeze.
    cur = ld_s;
    tick();
    cur = '0;
    tick();
    #1;
    chk("arst.pre_freeze4", o_frz[2], 1);
    rst_n = 1'b0;
    #1;
    chk("arst.freeze4", o_frz[2], 0);
    chk("arst.busy4", o_busy[2], 0);
    chk("arst.cnt4", o_cnt[2], 0);
    reset_model();
    tick();
    rst_n = 1'b1;
    idle(1);

    // Stall-cycle counter: three load-use events, then saturation.
    for (int e = 0; e < 3; e++) begin
      cur = lu_s;
      tick();
      idle(3);
    end
    #1;
    chk("perf.lat1", o_cnt[0], PERF ? 3 : 0);
    chk("perf.lat3", o_cnt[1], PERF ? 9 : 0);
    chk("perf.lat4", o_cnt[2], PERF ? 12 : 0);
    cur = lu_s;
    repeat (20) tick();
    #1;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("perf.sat%0d", g), o_cnt[g], PERF ? CMAX : 0);
    end

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      cur.rs  = AW'($urandom_range(0, 3));
      cur.rt  = AW'($urandom_range(0, 3));
      cur.rd  = AW'($urandom_range(0, 3));
      cur.rsu = ($urandom_range(0, 9) < 6);
      cur.rtu = ($urandom_range(0, 9) < 6);
      cur.vid = ($urandom_range(0, 9) < 9);
      cur.mr  = ($urandom_range(0, 9) < 4);
      cur.wb  = ($urandom_range(0, 9) < 8);
      cur.vx  = ($urandom_range(0, 9) < 8);
      cur.fl  = ($urandom_range(0, 9) < 1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
